// File: rtl/sha256_core_arbiter.sv
// Round-robin arbiter sharing one SHA-256 block core among NREQ requesters.
// One transaction in flight; a watchdog aborts if the core never reports done.
module sha256_core_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 128
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [NREQ-1:0]              i_req,
  input  logic [NREQ-1:0][7:0][31:0]   i_req_h_init,
  input  logic [NREQ-1:0][15:0][31:0]  i_req_block,
  output logic [NREQ-1:0]              o_gnt,
  output logic [NREQ-1:0]              o_rsp_valid,
  output logic [7:0][31:0]             o_rsp_hash,
  output logic                         o_rsp_err,
  output logic                         o_busy,
  output logic                         o_core_start,
  output logic [7:0][31:0]             o_core_h_init,
  output logic [15:0][31:0]            o_core_block,
  input  logic [7:0][31:0]             i_core_hash,
  input  logic                         i_core_done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                r_state;
  logic [PW-1:0]         r_rr;
  logic [PW-1:0]         r_owner;
  logic [CW-1:0]         r_cnt;
  logic [NREQ-1:0]       r_gnt;
  logic [NREQ-1:0]       r_rsp_valid;
  logic [7:0][31:0]      r_rsp_hash;
  logic                  r_rsp_err;
  logic                  r_busy;
  logic                  r_start;
  logic [7:0][31:0]      r_h_init;
  logic [15:0][31:0]     r_block;

  logic                  w_found;
  logic [PW-1:0]         w_win;

  // First requesting index at or above the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && i_req[(int'(r_rr) + k) % NREQ]) begin
        w_found = 1'b1;
        w_win   = PW'((int'(r_rr) + k) % NREQ);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_rr        <= '0;
      r_owner     <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_hash  <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_start     <= 1'b0;
      r_h_init    <= '0;
      r_block     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt    <= ONE << w_win;
            r_start  <= 1'b1;
            r_busy   <= 1'b1;
            r_h_init <= i_req_h_init[w_win];
            r_block  <= i_req_block[w_win];
            r_owner  <= w_win;
            r_rr     <= PW'((int'(w_win) + 1) % NREQ);
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_gnt   <= '0;
          r_start <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (i_core_done) begin
            r_rsp_hash  <= i_core_hash;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= ONE << r_owner;
            r_state     <= S_RESP;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_rsp_hash  <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= ONE << r_owner;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          r_rsp_valid <= '0;
          r_rsp_err   <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_gnt         = r_gnt;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_hash    = r_rsp_hash;
  assign o_rsp_err     = r_rsp_err;
  assign o_busy        = r_busy;
  assign o_core_start  = r_start;
  assign o_core_h_init = r_h_init;
  assign o_core_block  = r_block;

endmodule
